// File: rtl/irq_pkg.sv
// Shared interrupt-path types and sizes used by the gateway and the PLIC core.
package irq_pkg;

  localparam int unsigned NSRC = 32;
  localparam int unsigned IDW  = $clog2(NSRC);

  typedef logic [IDW-1:0] irq_id_t;

  typedef enum logic [1:0] {
    GW_IDLE,
    GW_PEND,
    GW_SERV
  } gw_state_e;

endpackage

// File: rtl/irq_gw_cell.sv
// One interrupt source: raw-line synchroniser, rising-edge detect and the
// idle/pending/in-service gateway state machine.
module irq_gw_cell
  import irq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  input  logic edge_sel_i,
  input  logic claim_hit_i,
  input  logic complete_hit_i,
  output logic pend_o,
  output logic inserv_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   mode_q, mode_d;
  logic                   edge_q, edge_d;
  gw_state_e              state_q, state_d;

  logic s, rise, req;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;
  assign req  = edge_sel_i ? rise : s;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    edge_d  = edge_q;
    unique case (state_q)
      GW_IDLE: begin
        if (req) begin
          state_d = GW_PEND;
          mode_d  = edge_sel_i;
        end
      end
      GW_PEND: begin
        if (claim_hit_i) begin
          state_d = GW_SERV;
        end else if (!mode_q && !s) begin
          state_d = GW_IDLE;
        end
      end
      GW_SERV: begin
        if (complete_hit_i) begin
          // A rise arriving in the completion cycle still counts as a queued edge.
          state_d = (mode_q && (edge_q || rise)) ? GW_PEND : GW_IDLE;
          edge_d  = 1'b0;
        end else if (mode_q && rise) begin
          edge_d = 1'b1;
        end
      end
      default: state_d = GW_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      mode_q  <= 1'b0;
      edge_q  <= 1'b0;
      state_q <= GW_IDLE;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      prev_q  <= s;
      mode_q  <= mode_d;
      edge_q  <= edge_d;
      state_q <= state_d;
    end
  end

  assign pend_o   = (state_q == GW_PEND);
  assign inserv_o = (state_q == GW_SERV);

endmodule

// File: rtl/irq_gateway.sv
// Interrupt gateway feeding the PLIC: decodes claim/complete IDs into per-source
// hits and instantiates one gateway cell per usable source (ID 0 is reserved).
module irq_gateway #(
  parameter int unsigned NSRC        = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned IDW         = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NSRC-1:0] irq_raw_i,
  input  logic [NSRC-1:0] edge_sel_i,
  input  logic            claim_valid_i,
  input  logic [IDW-1:0]  claim_id_i,
  input  logic            complete_valid_i,
  input  logic [IDW-1:0]  complete_id_i,
  output logic [NSRC-1:0] src_o,
  output logic [NSRC-1:0] inservice_o
);

  logic [NSRC-1:1] claim_hit;
  logic [NSRC-1:1] complete_hit;
  logic [NSRC-1:1] pend;
  logic [NSRC-1:1] inserv;

  // Only IDs 1..NSRC-1 can ever match, so ID 0 and out-of-range IDs fall through.
  always_comb begin
    claim_hit    = '0;
    complete_hit = '0;
    for (int unsigned i = 1; i < NSRC; i++) begin
      claim_hit[i]    = claim_valid_i && (32'(claim_id_i) == i);
      complete_hit[i] = complete_valid_i && (32'(complete_id_i) == i);
    end
  end

  for (genvar i = 1; i < NSRC; i++) begin : g_cell
    irq_gw_cell #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_cell (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .raw_i          (irq_raw_i[i]),
      .edge_sel_i     (edge_sel_i[i]),
      .claim_hit_i    (claim_hit[i]),
      .complete_hit_i (complete_hit[i]),
      .pend_o         (pend[i]),
      .inserv_o       (inserv[i])
    );
  end

  assign src_o       = {pend, 1'b0};
  assign inservice_o = {inserv, 1'b0};

  logic unused_src0;
  assign unused_src0 = irq_raw_i[0] ^ edge_sel_i[0];

endmodule
